// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM controller: command encodings, FSM states,
// mode-register fields and host address slicing.
package sdram_pkg;

    // {cs, ras, cas, we}, all active low
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    typedef enum logic [3:0] {
        INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_LMR,
        IDLE, ACT, RD, RD_DATA, WR, WR_BEAT1, PRE, REF, WAIT
    } state_t;

    localparam logic [2:0] MR_BL2     = 3'b001;
    localparam logic       MR_BT_SEQ  = 1'b0;

    localparam int BA_HI  = 24;
    localparam int BA_LO  = 23;
    localparam int ROW_HI = 22;
    localparam int ROW_LO = 10;
    localparam int COL_HI = 9;
    localparam int COL_LO = 1;

    localparam int WAIT_W = 16;

    function automatic logic [12:0] mode_word(input logic [2:0] cas);
        return {6'b0, cas, MR_BT_SEQ, MR_BL2};
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag.
// Expiry sets pending (and wins over a same-cycle clear); clr drops it otherwise.
module sdram_refresh_timer #(
    parameter int REFRESH_CYCLES = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic pending
);
    localparam int CW = $clog2(REFRESH_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          expire;

    always_comb begin
        expire = (cnt_q == CW'(REFRESH_CYCLES - 1));
        cnt_d  = expire ? '0 : cnt_q + 1'b1;
        pend_d = pend_q;
        if (clr)
            pend_d = 1'b0;
        if (expire)
            pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;

endmodule

// File: rtl/sdram_ctrl.sv
// Closed-page SDR SDRAM controller: one 32-bit host word becomes ACT / READ|WRITE (BL2) / PRE.
// Registered command pins; state names the command on the pins in that cycle.
module sdram_ctrl
    import sdram_pkg::*;
#(
    parameter int INIT_CYCLES    = 100,
    parameter int REFRESH_CYCLES = 780,
    parameter int T_RCD          = 2,
    parameter int T_RP           = 2,
    parameter int T_RFC          = 7,
    parameter int CAS_LAT        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_we,
    input  logic [24:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [3:0]  in_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        init_done,
    output logic        sdram_cke,
    output logic        sdram_cs,
    output logic        sdram_ras,
    output logic        sdram_cas,
    output logic        sdram_we,
    output logic [12:0] sdram_a,
    output logic [1:0]  sdram_ba,
    output logic [1:0]  sdram_dqm,
    inout  wire  [15:0] sdram_dq
);
    state_t              state_q, state_d, ret_q, ret_d, wait_tgt;
    logic [WAIT_W-1:0]   cnt_q, cnt_d, wait_n;
    logic                do_wait;
    logic                init_done_q, init_done_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic [15:0]         lo_q, lo_d;
    logic                we_q, we_d;
    logic [1:0]          bank_q, bank_d;
    logic [12:0]         row_q, row_d;
    logic [8:0]          col_q, col_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [12:0]         a_q, a_d;
    logic [1:0]          ba_q, ba_d, dqm_q, dqm_d;
    logic                dq_oe_q, dq_oe_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                refresh_pend, refresh_clr;
    wire                 unused_addr_lsb = in_addr[0];

    sdram_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_refresh (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (refresh_clr),
        .pending (refresh_pend)
    );

    assign in_ready = (state_q == IDLE) && init_done_q && !refresh_pend;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        lo_d        = lo_q;
        we_d        = we_q;
        bank_d      = bank_q;
        row_d       = row_q;
        col_d       = col_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        refresh_clr = 1'b0;
        do_wait     = 1'b0;
        wait_n      = '0;
        wait_tgt    = IDLE;
        case (state_q)
            INIT_WAIT: begin
                if (cnt_q == '0) state_d = INIT_PRE;
                else             cnt_d   = cnt_q - WAIT_W'(1);
            end
            INIT_PRE:  begin do_wait = 1'b1; wait_n = WAIT_W'(T_RP - 1);  wait_tgt = INIT_REF1; end
            INIT_REF1: begin do_wait = 1'b1; wait_n = WAIT_W'(T_RFC - 1); wait_tgt = INIT_REF2; end
            INIT_REF2: begin do_wait = 1'b1; wait_n = WAIT_W'(T_RFC - 1); wait_tgt = INIT_LMR;  end
            INIT_LMR:  begin do_wait = 1'b1; wait_n = WAIT_W'(2);         wait_tgt = IDLE;      end
            IDLE: begin
                if (refresh_pend) begin
                    state_d     = REF;
                    refresh_clr = 1'b1;
                end else if (in_valid && init_done_q) begin
                    we_d    = in_we;
                    bank_d  = in_addr[BA_HI:BA_LO];
                    row_d   = in_addr[ROW_HI:ROW_LO];
                    col_d   = in_addr[COL_HI:COL_LO];
                    wdata_d = in_wdata;
                    wstrb_d = in_wstrb;
                    state_d = ACT;
                end
            end
            ACT: begin
                do_wait  = 1'b1;
                wait_n   = WAIT_W'(T_RCD - 1);
                wait_tgt = we_q ? WR : RD;
            end
            RD: begin
                state_d = RD_DATA;
                cnt_d   = WAIT_W'(CAS_LAT);
            end
            // cnt reaches 1 on the low beat and 0 on the high beat
            RD_DATA: begin
                if (cnt_q == WAIT_W'(1))
                    lo_d = sdram_dq;
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = {sdram_dq, lo_q};
                    state_d     = PRE;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            WR:       state_d = WR_BEAT1;
            WR_BEAT1: state_d = PRE;
            PRE:  begin do_wait = 1'b1; wait_n = WAIT_W'(T_RP - 1);  wait_tgt = IDLE; end
            REF:  begin do_wait = 1'b1; wait_n = WAIT_W'(T_RFC - 1); wait_tgt = IDLE; end
            WAIT: begin
                if (cnt_q == '0) state_d = ret_q;
                else             cnt_d   = cnt_q - WAIT_W'(1);
            end
            default: state_d = INIT_WAIT;
        endcase
        if (do_wait) begin
            if (wait_n == '0) begin
                state_d = wait_tgt;
            end else begin
                state_d = WAIT;
                ret_d   = wait_tgt;
                cnt_d   = wait_n - WAIT_W'(1);
            end
        end
        if (state_d == IDLE)
            init_done_d = 1'b1;
    end

    // Pin values are decoded from the state being entered, so they line up with state_q.
    always_comb begin
        cmd_d    = CMD_NOP;
        a_d      = '0;
        ba_d     = '0;
        dqm_d    = '0;
        dq_oe_d  = 1'b0;
        dq_out_d = '0;
        case (state_d)
            INIT_PRE, PRE: begin
                cmd_d   = CMD_PRE;
                a_d[10] = 1'b1;
            end
            INIT_REF1, INIT_REF2, REF: cmd_d = CMD_REF;
            INIT_LMR: begin
                cmd_d = CMD_LMR;
                a_d   = mode_word(3'(CAS_LAT));
            end
            ACT: begin
                cmd_d = CMD_ACT;
                ba_d  = bank_d;
                a_d   = row_d;
            end
            RD: begin
                cmd_d = CMD_READ;
                ba_d  = bank_d;
                a_d   = {4'b0, col_d};
                dqm_d = 2'b11;
            end
            WR: begin
                cmd_d    = CMD_WRITE;
                ba_d     = bank_d;
                a_d      = {4'b0, col_d};
                dqm_d    = wstrb_d[1:0];
                dq_oe_d  = 1'b1;
                dq_out_d = wdata_d[15:0];
            end
            WR_BEAT1: begin
                dqm_d    = wstrb_d[3:2];
                dq_oe_d  = 1'b1;
                dq_out_d = wdata_d[31:16];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INIT_WAIT;
            ret_q       <= INIT_WAIT;
            cnt_q       <= WAIT_W'(INIT_CYCLES - 1);
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            lo_q        <= '0;
            we_q        <= 1'b0;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cmd_q       <= CMD_NOP;
            a_q         <= '0;
            ba_q        <= '0;
            dqm_q       <= '0;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            lo_q        <= lo_d;
            we_q        <= we_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cmd_q       <= cmd_d;
            a_q         <= a_d;
            ba_q        <= ba_d;
            dqm_q       <= dqm_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    assign {sdram_cs, sdram_ras, sdram_cas, sdram_we} = cmd_q;
    assign sdram_cke = 1'b1;
    assign sdram_a   = a_q;
    assign sdram_ba  = ba_q;
    assign sdram_dqm = dqm_q;
    assign sdram_dq  = dq_oe_q ? dq_out_q : 16'bz;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed bench for sdram_ctrl with a small SDRAM behavioural model on the pins.
module tb_sdram_ctrl;
    import sdram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_we;
    logic        in_ready;
    logic [24:0] in_addr;
    logic [31:0] in_wdata;
    logic [3:0]  in_wstrb;
    logic        rsp_valid, init_done;
    logic [31:0] rsp_rdata;
    logic        sdram_cke, sdram_cs, sdram_ras, sdram_cas, sdram_we;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_ba, sdram_dqm;
    wire  [15:0] sdram_dq;
    logic [3:0]  cmd;

    logic [15:0] mdq;
    logic        mdq_oe;
    logic [15:0] mem [logic [23:0]];
    logic [12:0] act_row [4];
    logic [23:0] rd_key, wr_key;
    int          rd_age;
    logic        wr_beat1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .sdram_cke(sdram_cke), .sdram_cs(sdram_cs), .sdram_ras(sdram_ras),
        .sdram_cas(sdram_cas), .sdram_we(sdram_we), .sdram_a(sdram_a),
        .sdram_ba(sdram_ba), .sdram_dqm(sdram_dqm), .sdram_dq(sdram_dq)
    );

    assign cmd      = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
    assign sdram_dq = mdq_oe ? mdq : 16'bz;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] m);
        logic [15:0] r;
        r = old;
        if (m[0]) r[7:0]  = d[7:0];
        if (m[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    function automatic logic [15:0] mem_rd(input logic [23:0] k);
        return mem.exists(k) ? mem[k] : 16'h0000;
    endfunction

    // Memory model acts mid-cycle when the registered pins are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_age   = -1;
            wr_beat1 = 1'b0;
            mdq_oe   = 1'b0;
        end else begin
            if (wr_beat1) begin
                mem[wr_key + 24'd1] = merge(mem_rd(wr_key + 24'd1), sdram_dq, sdram_dqm);
                wr_beat1 = 1'b0;
            end
            if (cmd == CMD_ACT)
                act_row[sdram_ba] = sdram_a;
            if (cmd == CMD_WRITE) begin
                wr_key      = {sdram_ba, act_row[sdram_ba], sdram_a[8:0]};
                mem[wr_key] = merge(mem_rd(wr_key), sdram_dq, sdram_dqm);
                wr_beat1    = 1'b1;
            end
            if (cmd == CMD_READ) begin
                rd_key = {sdram_ba, act_row[sdram_ba], sdram_a[8:0]};
                rd_age = 0;
            end else if (rd_age >= 0) begin
                rd_age++;
                if (rd_age == 2) begin
                    mdq = mem_rd(rd_key); mdq_oe = 1'b1;
                end else if (rd_age == 3) begin
                    mdq = mem_rd(rd_key + 24'd1);
                end else if (rd_age == 4) begin
                    mdq_oe = 1'b0; rd_age = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cmd(output logic [3:0] c, output int gap);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (cmd == CMD_NOP && gap < 400);
        c = cmd;
    endtask

    task automatic check_init();
        int nops, pulses, gap;
        logic [3:0] c;
        nops = 0;
        pulses = 0;
        while (cmd == CMD_NOP && nops < 400) begin
            if (rsp_valid) pulses++;
            nops++;
            tick();
        end
        chk("init_nops", 32'(nops), 32'd100);
        chk("no_rsp_in_init", 32'(pulses), 32'd0);
        chk("init_pre", 32'(cmd), 32'(CMD_PRE));
        chk("init_pre_a10", 32'(sdram_a[10]), 32'd1);
        wait_cmd(c, gap);
        chk("init_ref1", 32'(c), 32'(CMD_REF));
        chk("init_ref1_gap", 32'(gap), 32'd2);
        wait_cmd(c, gap);
        chk("init_ref2", 32'(c), 32'(CMD_REF));
        chk("init_ref2_gap", 32'(gap), 32'd7);
        wait_cmd(c, gap);
        chk("init_lmr", 32'(c), 32'(CMD_LMR));
        chk("init_lmr_gap", 32'(gap), 32'd7);
        chk("init_lmr_a", 32'(sdram_a), 32'h021);
        chk("init_lmr_done_low", 32'(init_done), 32'd0);
        gap = 0;
        while (!in_ready && gap < 50) begin
            tick();
            gap++;
        end
        chk("init_ready_gap", 32'(gap), 32'd3);
        chk("init_done", 32'(init_done), 32'd1);
    endtask

    task automatic host_req(input logic we, input logic [24:0] addr,
                            input logic [31:0] wd, input logic [3:0] ws);
        int n;
        in_valid = 1'b1; in_we = we; in_addr = addr; in_wdata = wd; in_wstrb = ws;
        n = 0;
        while (!in_ready && n < 1000) begin
            tick();
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_write(input logic [24:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                            input logic [1:0] eba, input logic [12:0] erow, input logic [8:0] ecol,
                            input logic [1:0] edqm0, input logic [1:0] edqm1);
        host_req(1'b1, addr, wd, ws);
        chk("wr_act", 32'(cmd), 32'(CMD_ACT));
        chk("wr_act_ba", 32'(sdram_ba), 32'(eba));
        chk("wr_act_row", 32'(sdram_a), 32'(erow));
        tick();
        tick();
        chk("wr_cmd", 32'(cmd), 32'(CMD_WRITE));
        chk("wr_col", 32'(sdram_a), 32'(ecol));
        chk("wr_dq0", 32'(sdram_dq), 32'(wd[15:0]));
        chk("wr_dqm0", 32'(sdram_dqm), 32'(edqm0));
        tick();
        chk("wr_beat1_nop", 32'(cmd), 32'(CMD_NOP));
        chk("wr_dq1", 32'(sdram_dq), 32'(wd[31:16]));
        chk("wr_dqm1", 32'(sdram_dqm), 32'(edqm1));
        tick();
        chk("wr_pre", 32'(cmd), 32'(CMD_PRE));
        chk("wr_dq_released", 32'(dut.dq_oe_q), 32'd0);
    endtask

    task automatic check_read(input logic [1:0] eba, input logic [12:0] erow,
                              input logic [8:0] ecol, input logic [31:0] edata);
        int lat;
        chk("rd_act", 32'(cmd), 32'(CMD_ACT));
        chk("rd_act_ba", 32'(sdram_ba), 32'(eba));
        chk("rd_act_row", 32'(sdram_a), 32'(erow));
        tick();
        tick();
        chk("rd_cmd", 32'(cmd), 32'(CMD_READ));
        chk("rd_ba", 32'(sdram_ba), 32'(eba));
        chk("rd_col", 32'(sdram_a), 32'(ecol));
        chk("rd_dqm", 32'(sdram_dqm), 32'd3);
        chk("rd_dq_undriven", 32'(dut.dq_oe_q), 32'd0);
        lat = 3;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("rd_latency", 32'(lat), 32'd7);
        chk("rd_data", rsp_rdata, edata);
        chk("rd_pre_with_rsp", 32'(cmd), 32'(CMD_PRE));
        tick();
        chk("rd_rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("rd_data_hold", rsp_rdata, edata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, n;
        rst_n = 1'b0; in_valid = 1'b0; in_we = 1'b0;
        in_addr = '0; in_wdata = '0; in_wstrb = '0;
        mdq = '0; mdq_oe = 1'b0; rd_age = -1; wr_beat1 = 1'b0;
        repeat (3) tick();

        chk("rst_cmd", 32'(cmd), 32'(CMD_NOP));
        chk("rst_a", 32'(sdram_a), 32'd0);
        chk("rst_ba", 32'(sdram_ba), 32'd0);
        chk("rst_dqm", 32'(sdram_dqm), 32'd0);
        chk("rst_dq_z", 32'(dut.dq_oe_q), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("cke", 32'(sdram_cke), 32'd1);

        rst_n = 1'b1;
        check_init();

        do_write(25'h0000100, 32'hDEADBEEF, 4'hF, 2'd0, 13'd0, 9'h080, 2'b11, 2'b11);
        host_req(1'b0, 25'h0000100, 32'h0, 4'h0);
        check_read(2'd0, 13'd0, 9'h080, 32'hDEADBEEF);

        do_write(25'h0000100, 32'h11223344, 4'b0101, 2'd0, 13'd0, 9'h080, 2'b01, 2'b01);
        host_req(1'b0, 25'h0000100, 32'h0, 4'h0);
        check_read(2'd0, 13'd0, 9'h080, 32'hDE22BE44);

        do_write(25'h1FFFFFC, 32'hCAFEF00D, 4'hF, 2'd3, 13'h1FFF, 9'h1FE, 2'b11, 2'b11);
        host_req(1'b0, 25'h1FFFFFC, 32'h0, 4'h0);
        check_read(2'd3, 13'h1FFF, 9'h1FE, 32'hCAFEF00D);

        // Wait in IDLE for the refresh interval to expire, then request with it pending.
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        n = 0;
        while (in_ready && n < 1000) begin tick(); n++; end
        in_valid = 1'b1; in_we = 1'b0; in_addr = 25'h0000100;
        tick();
        chk("ref_first", 32'(cmd), 32'(CMD_REF));
        chk("ref_not_ready", 32'(in_ready), 32'd0);
        gap = 0;
        while (!in_ready && gap < 50) begin tick(); gap++; end
        chk("ref_trfc_gap", 32'(gap), 32'd7);
        tick();
        in_valid = 1'b0;
        check_read(2'd0, 13'd0, 9'h080, 32'hDE22BE44);

        // Reset pulse while waiting for read data.
        host_req(1'b0, 25'h0000100, 32'h0, 4'h0);
        tick();
        tick();
        chk("mid_rd_cmd", 32'(cmd), 32'(CMD_READ));
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_nop", 32'(cmd), 32'(CMD_NOP));
        chk("mid_rst_dq_z", 32'(dut.dq_oe_q), 32'd0);
        chk("mid_rst_init_done", 32'(init_done), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        check_init();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
